// File: rtl/martian_date_counter.sv
// Martian (Darian-style) calendar counter.
// Keeps a year/month/sol date that advances one sol per tick and accepts a
// validated load of a new date. The 27/28-sol month rule used to decide when
// to roll over is the same one presented on month_len for downstream decode.

module martian_date_counter #(
   parameter int YEAR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              load,
   input  logic [YEAR_W-1:0] ld_year,
   input  logic [4:0]        ld_month,
   input  logic [4:0]        ld_sol,
   output logic [YEAR_W-1:0] year,
   output logic [4:0]        month,
   output logic [4:0]        sol,
   output logic              leap_year,
   output logic [4:0]        month_len,
   output logic              month_wrap,
   output logic              year_wrap,
   output logic              load_err
);

   // Calendar constants. Months run 0..23 and sols are 1-based.
   localparam logic [4:0]        LAST_MONTH = 5'd23;
   localparam logic [4:0]        FIRST_SOL  = 5'd1;
   localparam logic [4:0]        LEN_SHORT  = 5'd27;
   localparam logic [4:0]        LEN_LONG   = 5'd28;
   localparam logic [YEAR_W-1:0] TEN        = YEAR_W'(10);
   localparam logic [YEAR_W-1:0] YEAR_ONE   = YEAR_W'(1);

   // A year is leap when it is odd or a multiple of ten.
   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      return y[0] || ((y % TEN) == '0);
   endfunction

   // Even months are long; odd months are short except the last month of a
   // leap year, which carries the extra sol.
   function automatic logic [4:0] len_of(input logic [4:0] m, input logic leap);
      logic [4:0] len;
      if (!m[0])
         len = LEN_LONG;
      else if ((m == LAST_MONTH) && leap)
         len = LEN_LONG;
      else
         len = LEN_SHORT;
      return len;
   endfunction

   logic              cur_leap;
   logic [4:0]        cur_len;

   logic              ld_leap;
   logic [4:0]        ld_len;
   logic              ld_ok;

   logic [YEAR_W-1:0] tick_year;
   logic [4:0]        tick_month;
   logic [4:0]        tick_sol;
   logic              tick_mwrap;
   logic              tick_ywrap;

   logic [YEAR_W-1:0] next_year;
   logic [4:0]        next_month;
   logic [4:0]        next_sol;
   logic              next_mwrap;
   logic              next_ywrap;
   logic              next_lerr;

   // Leap status and month length of the date currently held.
   always_comb begin
      cur_leap = is_leap(year);
      cur_len  = len_of(month, cur_leap);
   end

   // Validate the load request against the length of the month being loaded.
   always_comb begin
      ld_leap = is_leap(ld_year);
      ld_len  = len_of(ld_month, ld_leap);
      ld_ok   = (ld_month <= LAST_MONTH) && (ld_sol >= FIRST_SOL) && (ld_sol <= ld_len);
   end

   // Date one sol after the current one, with the roll-over pulses it causes.
   always_comb begin
      tick_year  = year;
      tick_month = month;
      tick_sol   = sol;
      tick_mwrap = 1'b0;
      tick_ywrap = 1'b0;
      if (sol < cur_len) begin
         tick_sol = sol + 5'd1;
      end else if (month < LAST_MONTH) begin
         tick_sol   = FIRST_SOL;
         tick_month = month + 5'd1;
         tick_mwrap = 1'b1;
      end else begin
         tick_sol   = FIRST_SOL;
         tick_month = '0;
         tick_year  = year + YEAR_ONE;
         tick_mwrap = 1'b1;
         tick_ywrap = 1'b1;
      end
   end

   // Choose the next state: a load (legal or not) always beats a tick.
   always_comb begin
      next_year  = year;
      next_month = month;
      next_sol   = sol;
      next_mwrap = 1'b0;
      next_ywrap = 1'b0;
      next_lerr  = 1'b0;
      if (load) begin
         if (ld_ok) begin
            next_year  = ld_year;
            next_month = ld_month;
            next_sol   = ld_sol;
         end else begin
            next_lerr = 1'b1;
         end
      end else if (tick) begin
         next_year  = tick_year;
         next_month = tick_month;
         next_sol   = tick_sol;
         next_mwrap = tick_mwrap;
         next_ywrap = tick_ywrap;
      end
   end

   // Date and pulse registers; reset drops back to 0/0/1 with pulses cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         year       <= '0;
         month      <= '0;
         sol        <= FIRST_SOL;
         month_wrap <= 1'b0;
         year_wrap  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         year       <= next_year;
         month      <= next_month;
         sol        <= next_sol;
         month_wrap <= next_mwrap;
         year_wrap  <= next_ywrap;
         load_err   <= next_lerr;
      end
   end

   // Expose the decoded calendar attributes of the current date.
   always_comb begin
      leap_year = cur_leap;
      month_len = cur_len;
   end

endmodule

// File: tb/tb_martian_date_counter.sv
// Directed testbench for martian_date_counter.
// Inputs change 1 ns after a rising edge and outputs are checked there too.

module tb_martian_date_counter;

   logic        clk;
   logic        reset;
   logic        tick;
   logic        load;
   logic [15:0] ld_year;
   logic [4:0]  ld_month;
   logic [4:0]  ld_sol;
   logic [15:0] year;
   logic [4:0]  month;
   logic [4:0]  sol;
   logic        leap_year;
   logic [4:0]  month_len;
   logic        month_wrap;
   logic        year_wrap;
   logic        load_err;

   int vectors;
   int miscompares;

   martian_date_counter #(.YEAR_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .load       (load),
      .ld_year    (ld_year),
      .ld_month   (ld_month),
      .ld_sol     (ld_sol),
      .year       (year),
      .month      (month),
      .sol        (sol),
      .leap_year  (leap_year),
      .month_len  (month_len),
      .month_wrap (month_wrap),
      .year_wrap  (year_wrap),
      .load_err   (load_err)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required finish");
      $fatal(1, "[TB] watchdog");
   end

   // Apply one cycle of tick/load stimulus, then release the controls.
   task automatic drive(input logic t, input logic l, input logic [15:0] y,
                        input logic [4:0] m, input logic [4:0] s);
      tick     = t;
      load     = l;
      ld_year  = y;
      ld_month = m;
      ld_sol   = s;
      @(posedge clk);
      #1;
      tick = 1'b0;
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick  = 1'b0;
      load  = 1'b0;
      ld_year = '0; ld_month = '0; ld_sol = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      vectors++;
      if ({year, month, sol} !== {16'd0, 5'd0, 5'd1}) begin
         miscompares++;
         $display("[TB] FAIL reset_date: got %0d/%0d/%0d, expected 0/0/1", year, month, sol);
      end
      vectors++;
      if ({month_wrap, year_wrap, load_err} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_pulses: got %b, expected 000", {month_wrap, year_wrap, load_err});
      end
      vectors++;
      if ({leap_year, month_len} !== {1'b1, 5'd28}) begin
         miscompares++;
         $display("[TB] FAIL reset_decode: got leap=%b len=%0d, expected leap=1 len=28", leap_year, month_len);
      end
   endtask

   task automatic test_tick_month();
      for (int i = 0; i < 27; i++) drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap} !== {16'd0, 5'd0, 5'd28, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL tick27: got %0d/%0d/%0d mw=%b, expected 0/0/28 mw=0", year, month, sol, month_wrap);
      end
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap, year_wrap} !== {16'd0, 5'd1, 5'd1, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL tick28: got %0d/%0d/%0d mw=%b yw=%b, expected 0/1/1 mw=1 yw=0",
                  year, month, sol, month_wrap, year_wrap);
      end
      drive(1'b0, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap} !== {16'd0, 5'd1, 5'd1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL idle_hold: got %0d/%0d/%0d mw=%b, expected 0/1/1 mw=0", year, month, sol, month_wrap);
      end
      vectors++;
      if (month_len !== 5'd27) begin
         miscompares++;
         $display("[TB] FAIL len_month1: got %0d, expected 27", month_len);
      end
   endtask

   task automatic test_load_common();
      drive(1'b0, 1'b1, 16'd2, 5'd1, 5'd27);
      vectors++;
      if ({year, month, sol, load_err, leap_year, month_len} !== {16'd2, 5'd1, 5'd27, 1'b0, 1'b0, 5'd27}) begin
         miscompares++;
         $display("[TB] FAIL load_2_1_27: got %0d/%0d/%0d err=%b leap=%b len=%0d, expected 2/1/27 err=0 leap=0 len=27",
                  year, month, sol, load_err, leap_year, month_len);
      end
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap, year_wrap} !== {16'd2, 5'd2, 5'd1, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL tick_2_1_27: got %0d/%0d/%0d mw=%b yw=%b, expected 2/2/1 mw=1 yw=0",
                  year, month, sol, month_wrap, year_wrap);
      end
   endtask

   task automatic test_year_common();
      drive(1'b0, 1'b1, 16'd2, 5'd23, 5'd27);
      vectors++;
      if ({year, month, sol, month_len} !== {16'd2, 5'd23, 5'd27, 5'd27}) begin
         miscompares++;
         $display("[TB] FAIL load_2_23_27: got %0d/%0d/%0d len=%0d, expected 2/23/27 len=27",
                  year, month, sol, month_len);
      end
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap, year_wrap} !== {16'd3, 5'd0, 5'd1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL yearwrap_common: got %0d/%0d/%0d mw=%b yw=%b, expected 3/0/1 mw=1 yw=1",
                  year, month, sol, month_wrap, year_wrap);
      end
   endtask

   task automatic test_leap_month();
      drive(1'b0, 1'b1, 16'd3, 5'd23, 5'd27);
      vectors++;
      if ({leap_year, month_len} !== {1'b1, 5'd28}) begin
         miscompares++;
         $display("[TB] FAIL leap3_decode: got leap=%b len=%0d, expected leap=1 len=28", leap_year, month_len);
      end
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap, year_wrap} !== {16'd3, 5'd23, 5'd28, 1'b0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL leap_sol28: got %0d/%0d/%0d mw=%b yw=%b, expected 3/23/28 mw=0 yw=0",
                  year, month, sol, month_wrap, year_wrap);
      end
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap, year_wrap} !== {16'd4, 5'd0, 5'd1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL leap_yearwrap: got %0d/%0d/%0d mw=%b yw=%b, expected 4/0/1 mw=1 yw=1",
                  year, month, sol, month_wrap, year_wrap);
      end
      drive(1'b0, 1'b1, 16'd10, 5'd23, 5'd28);
      vectors++;
      if ({year, month, sol, load_err, leap_year} !== {16'd10, 5'd23, 5'd28, 1'b0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL load_10_23_28: got %0d/%0d/%0d err=%b leap=%b, expected 10/23/28 err=0 leap=1",
                  year, month, sol, load_err, leap_year);
      end
   endtask

   task automatic test_load_errors();
      logic [15:0] ey [4] = '{16'd4, 16'd4, 16'd4, 16'd4};
      logic [4:0]  em [4] = '{5'd1, 5'd24, 5'd0, 5'd23};
      logic [4:0]  es [4] = '{5'd28, 5'd1, 5'd0, 5'd28};
      drive(1'b0, 1'b1, 16'd4, 5'd0, 5'd1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, ey[i], em[i], es[i]);
         vectors++;
         if ({year, month, sol, load_err} !== {16'd4, 5'd0, 5'd1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL bad_load_%0d: got %0d/%0d/%0d err=%b, expected 4/0/1 err=1",
                     i, year, month, sol, load_err);
         end
      end
      drive(1'b0, 1'b0, '0, '0, '0);
      vectors++;
      if (load_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL err_one_cycle: got %b, expected 0", load_err);
      end
   endtask

   task automatic test_year_overflow();
      drive(1'b0, 1'b1, 16'd65535, 5'd23, 5'd28);
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap, year_wrap} !== {16'd0, 5'd0, 5'd1, 1'b1, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL year_overflow: got %0d/%0d/%0d mw=%b yw=%b, expected 0/0/1 mw=1 yw=1",
                  year, month, sol, month_wrap, year_wrap);
      end
   endtask

   task automatic test_load_tick();
      drive(1'b0, 1'b1, 16'd7, 5'd0, 5'd28);
      drive(1'b1, 1'b1, 16'd7, 5'd5, 5'd3);
      vectors++;
      if ({year, month, sol, month_wrap, load_err} !== {16'd7, 5'd5, 5'd3, 1'b0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL load_beats_tick: got %0d/%0d/%0d mw=%b err=%b, expected 7/5/3 mw=0 err=0",
                  year, month, sol, month_wrap, load_err);
      end
      drive(1'b1, 1'b1, 16'd7, 5'd24, 5'd1);
      vectors++;
      if ({year, month, sol, load_err} !== {16'd7, 5'd5, 5'd3, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL bad_load_drops_tick: got %0d/%0d/%0d err=%b, expected 7/5/3 err=1",
                  year, month, sol, load_err);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 16'd9, 5'd0, 5'd28);
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol, month_wrap} !== {16'd9, 5'd1, 5'd1, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL pre_reset: got %0d/%0d/%0d mw=%b, expected 9/1/1 mw=1", year, month, sol, month_wrap);
      end
      #1;
      reset = 1'b1;
      #1;
      vectors++;
      if ({year, month, sol, month_wrap, year_wrap, load_err} !== {16'd0, 5'd0, 5'd1, 3'b000}) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got %0d/%0d/%0d pulses=%b, expected 0/0/1 pulses=000",
                  year, month, sol, {month_wrap, year_wrap, load_err});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 1'b0, '0, '0, '0);
      vectors++;
      if ({year, month, sol} !== {16'd0, 5'd0, 5'd2}) begin
         miscompares++;
         $display("[TB] FAIL post_reset_tick: got %0d/%0d/%0d, expected 0/0/2", year, month, sol);
      end
   endtask

   // Run the scenarios in order and report.
   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_tick_month();
      test_load_common();
      test_year_common();
      test_leap_month();
      test_load_errors();
      test_year_overflow();
      test_load_tick();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
